// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter states, tracking-entry layout
// and the RV32 conditional-branch opcode.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_t;

  localparam bp_state_t BP_MISS_STATE = WNT;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    bp_state_t  state;
  } bp_entry_t;

  function automatic logic is_cond_branch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step: prior state plus resolved
// direction gives the next state and whether the prior state mispredicted.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_state_t state,
  input  logic      taken,
  output bp_state_t next,
  output logic      mispredict
);

  logic [1:0] raw;

  always_comb begin
    raw = state;
    if (taken) begin
      if (state != ST) raw = state + 2'd1;
    end else begin
      if (state != SNT) raw = state - 2'd1;
    end
    next       = bp_state_t'(raw);
    mispredict = state[1] != taken;
  end

endmodule

// File: rtl/bht_update_unit.sv
// Carries each BHT prediction from fetch to execute, then produces the
// registered BHT write-back, the fetch redirect and two saturating counters.
module bht_update_unit
  import bp_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [31:0] pc1,
  input  logic [1:0]  prediction,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_br_valid,
  input  logic        ex_br_taken,
  input  logic [31:0] pc2,
  input  logic [31:0] ex_target,
  output logic        write,
  output logic [1:0]  updated_logic,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  bp_entry_t entry [PIPE_DEPTH];

  bp_entry_t   ex_entry;
  bp_state_t   prior;
  bp_state_t   next_state;
  logic        sc_mispredict;
  logic        fire;
  logic        hit;
  logic [31:0] redirect_next;
  logic        br_inc;
  logic        mp_inc;
  logic [31:0] br_count_q;
  logic [31:0] mp_count_q;

  // Flush clears valids only; pc/state of dead entries are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) entry[i].valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) entry[i].valid <= 1'b0;
    end else if (!stall) begin
      entry[0].valid <= read;
      entry[0].pc    <= pc1;
      entry[0].state <= read ? bp_state_t'(prediction) : BP_MISS_STATE;
      for (int i = 1; i < PIPE_DEPTH; i++) entry[i] <= entry[i-1];
    end
  end

  assign ex_entry      = entry[PIPE_DEPTH-1];
  assign hit           = ex_entry.valid && (ex_entry.pc == pc2);
  assign prior         = hit ? ex_entry.state : BP_MISS_STATE;
  assign fire          = ex_br_valid && !stall;
  assign redirect_next = ex_br_taken ? ex_target : pc2 + 32'd4;

  bp_sat_counter u_sat_counter (
    .state      (prior),
    .taken      (ex_br_taken),
    .next       (next_state),
    .mispredict (sc_mispredict)
  );

  assign br_inc = fire && (br_count_q != 32'hFFFF_FFFF);
  assign mp_inc = fire && sc_mispredict && (mp_count_q != 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      write         <= 1'b0;
      updated_logic <= BP_MISS_STATE;
      mispredict    <= 1'b0;
      redirect_pc   <= 32'h0;
      br_count_q    <= 32'h0;
      mp_count_q    <= 32'h0;
    end else begin
      write      <= fire;
      mispredict <= fire && sc_mispredict;
      if (fire) updated_logic <= next_state;
      if (fire && sc_mispredict) redirect_pc <= redirect_next;
      br_count_q <= br_count_q + {31'b0, br_inc};
      mp_count_q <= mp_count_q + {31'b0, mp_inc};
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule
